// File: rtl/vx_tex_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vx_tex_fetch
// Purpose  : Texel gather stage. Latches one warp-wide request carrying four
//            texel byte addresses per lane, issues up to four memory reads
//            (tags 0..3), collects out-of-order responses, byte-aligns each
//            word and presents the quad of texels per lane to the sampler.
// Options  : TEX_FETCH_DEDUP_EN - skip quad indices whose active-lane word
//            addresses repeat the previous index (alias instead of re-read).
// Revision : 1.0 - initial release
// ============================================================================
`ifndef TEX_FORMAT_BITS
`define TEX_FORMAT_BITS 3
`endif
`ifndef TEX_BLEND_FRAC
`define TEX_BLEND_FRAC 8
`endif

module vx_tex_fetch #(
    parameter int CORE_ID   = 0,
    parameter int REQ_INFOW = 1,
    parameter int NUM_REQS  = 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          req_valid,
    input  logic [NUM_REQS-1:0]                           req_tmask,
    input  logic [`TEX_FORMAT_BITS-1:0]                   req_format,
    input  logic [NUM_REQS-1:0][1:0][`TEX_BLEND_FRAC-1:0] req_blends,
    input  logic [NUM_REQS-1:0][3:0][31:0]                req_addr,
    input  logic [REQ_INFOW-1:0]                          req_info,
    output logic                                          req_ready,
    output logic                                          mem_req_valid,
    output logic [NUM_REQS-1:0]                           mem_req_mask,
    output logic [NUM_REQS-1:0][29:0]                     mem_req_addr,
    output logic [1:0]                                    mem_req_tag,
    input  logic                                          mem_req_ready,
    input  logic                                          mem_rsp_valid,
    input  logic [NUM_REQS-1:0][31:0]                     mem_rsp_data,
    input  logic [1:0]                                    mem_rsp_tag,
    output logic                                          mem_rsp_ready,
    output logic                                          rsp_valid,
    output logic [NUM_REQS-1:0]                           rsp_tmask,
    output logic [`TEX_FORMAT_BITS-1:0]                   rsp_format,
    output logic [NUM_REQS-1:0][1:0][`TEX_BLEND_FRAC-1:0] rsp_blends,
    output logic [NUM_REQS-1:0][3:0][31:0]                rsp_data,
    output logic [REQ_INFOW-1:0]                          rsp_info,
    input  logic                                          rsp_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t                                        r_state, w_state_next;
    logic [NUM_REQS-1:0]                           r_tmask;
    logic [`TEX_FORMAT_BITS-1:0]                   r_format;
    logic [NUM_REQS-1:0][1:0][`TEX_BLEND_FRAC-1:0] r_blends;
    logic [NUM_REQS-1:0][3:0][31:0]                r_addr;
    logic [REQ_INFOW-1:0]                          r_info;
    logic [3:0][NUM_REQS-1:0][31:0]                r_slot;
    logic [1:0]                                    r_q;
    logic [3:0]                                    r_received;
    logic                                          r_flush;

    logic       w_accept;
    logic       w_adv;
    logic       w_skip;
    logic       w_tag_free;
    logic       w_rsp_new;
    logic       w_done;
    logic       w_proto_err;
    logic [3:0] w_rcv_next;
    logic [3:0][1:0] w_src;

    assign w_accept   = (r_state == IDLE) && req_valid;
    assign w_adv      = (r_state == ISSUE) && (w_skip || mem_req_ready);
    assign w_rsp_new  = mem_rsp_valid && (r_state != IDLE) && w_tag_free;
    assign w_rcv_next = r_received | (w_rsp_new ? (4'b0001 << mem_rsp_tag) : 4'b0000);

`ifdef TEX_FETCH_DEDUP_EN
    logic [3:0] r_alias;
    logic [3:0] w_alias_next;
    logic [3:0] w_eff;

    assign w_tag_free   = !r_received[mem_rsp_tag] && !r_alias[mem_rsp_tag];
    assign w_alias_next = r_alias | (w_skip ? (4'b0001 << r_q) : 4'b0000);

    // Skip index q when every active lane reads the same word as index q-1
    always_comb begin
        w_skip = (r_state == ISSUE) && (r_q != 2'd0);
        for (int i = 0; i < NUM_REQS; i++) begin
            if (r_tmask[i] && (r_addr[i][r_q][31:2] != r_addr[i][r_q - 2'd1][31:2]))
                w_skip = 1'b0;
        end
    end

    // Alias chains resolve to the nearest real slot; aliases complete with their source
    always_comb begin
        w_eff    = '0;
        w_src    = '0;
        w_eff[0] = w_rcv_next[0];
        for (int j = 1; j < 4; j++) begin
            w_eff[j] = w_alias_next[j] ? w_eff[j-1] : w_rcv_next[j];
            w_src[j] = r_alias[j] ? w_src[j-1] : 2'(j);
        end
        w_done = &w_eff;
    end

    // Alias bookkeeping, cleared for every new request
    always_ff @(posedge clk) begin
        if (reset)
            r_alias <= '0;
        else if (w_accept)
            r_alias <= '0;
        else if (w_skip)
            r_alias[r_q] <= 1'b1;
    end
`else
    assign w_tag_free = !r_received[mem_rsp_tag];
    assign w_skip     = 1'b0;

    // Every quad index owns its slot; completion needs all four responses
    always_comb begin
        w_src = '0;
        for (int j = 0; j < 4; j++)
            w_src[j] = 2'(j);
        w_done = &w_rcv_next;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next  = r_state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        rsp_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    w_state_next = ISSUE;
            end
            ISSUE: begin
                mem_req_valid = !w_skip;
                if (w_adv && (r_q == 2'd3))
                    w_state_next = w_done ? OUTPUT : WAIT;
            end
            WAIT: begin
                if (w_done)
                    w_state_next = OUTPUT;
            end
            OUTPUT: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Request latch, issue index, response slots and received mask
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmask    <= '0;
            r_format   <= '0;
            r_blends   <= '0;
            r_addr     <= '0;
            r_info     <= '0;
            r_slot     <= '0;
            r_q        <= '0;
            r_received <= '0;
            r_flush    <= 1'b1;
        end else if (w_accept) begin
            r_tmask    <= req_tmask;
            r_format   <= req_format;
            r_blends   <= req_blends;
            r_addr     <= req_addr;
            r_info     <= req_info;
            r_q        <= '0;
            r_received <= '0;
            r_flush    <= 1'b0;
        end else begin
            if (w_adv)
                r_q <= r_q + 2'd1;
            if (w_rsp_new) begin
                r_received[mem_rsp_tag] <= 1'b1;
                r_slot[mem_rsp_tag]     <= mem_rsp_data;
            end
        end
    end

    // Memory request payload for the current quad index
    always_comb begin
        mem_req_addr = '0;
        for (int i = 0; i < NUM_REQS; i++)
            mem_req_addr[i] = r_addr[i][r_q][31:2];
    end

    assign mem_req_mask  = r_tmask;
    assign mem_req_tag   = r_q;
    assign mem_rsp_ready = 1'b1;
    assign rsp_tmask     = r_tmask;
    assign rsp_format    = r_format;
    assign rsp_blends    = r_blends;
    assign rsp_info      = r_info;

    // Byte-align each texel; inactive lanes and non-output states read zero
    always_comb begin
        rsp_data = '0;
        if (r_state == OUTPUT) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                for (int j = 0; j < 4; j++) begin
                    if (r_tmask[i])
                        rsp_data[i][j] = r_slot[w_src[j]][i] >> {r_addr[i][j][1:0], 3'b000};
                end
            end
        end
    end

    // Duplicate tags, or responses in IDLE after a completed request, break protocol
    assign w_proto_err = mem_rsp_valid &&
                         (((r_state == IDLE) && !r_flush) || ((r_state != IDLE) && !w_tag_free));

    // Protocol check on the memory response channel
    always_ff @(posedge clk) begin
        if (!reset)
            assert (!w_proto_err)
                else $error("vx_tex_fetch core %0d: unexpected memory response tag %0d", CORE_ID, mem_rsp_tag);
    end

endmodule

`default_nettype wire

// File: doc/vx_tex_fetch.md
# VX_tex_fetch

Texel gather stage directly upstream of the texture sampler. It accepts one warp-wide request carrying four texel byte addresses per lane, issues up to four warp-wide read requests to the texture memory port, and collects responses that may return out of order. It aligns each returned 32-bit word to its byte offset and hands the complete quad of texels per lane, together with the unchanged format, blend fractions, tmask and info, to the sampler over a valid/ready handshake.

## Interface
- CORE_ID, 0, core index; used only for tracing.
- REQ_INFOW, 1, width of the opaque request info passed through.
- NUM_REQS, 1, number of lanes.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_tmask  in  NUM_REQS  active lanes.
- req_format  in  `TEX_FORMAT_BITS  texel format; passed through.
- req_blends  in  NUM_REQS×2×`TEX_BLEND_FRAC  u/v blend fractions; passed through.
- req_addr  in  NUM_REQS×4×32  texel byte addresses, quad index 0..3.
- req_info  in  REQ_INFOW  passed through.
- req_ready  out  1  request accepted when high with req_valid.
- mem_req_valid  out  1  memory read request valid.
- mem_req_mask  out  NUM_REQS  lanes requested (= latched tmask).
- mem_req_addr  out  NUM_REQS×30  word addresses (byte addr[31:2]).
- mem_req_tag  out  2  quad index of this request.
- mem_req_ready  in  1  memory accepts request.
- mem_rsp_valid  in  1  response valid.
- mem_rsp_data  in  NUM_REQS×32  returned words.
- mem_rsp_tag  in  2  quad index of response.
- mem_rsp_ready  out  1  tied high.
- rsp_valid  out  1  output valid.
- rsp_tmask  out  NUM_REQS, rsp_format, rsp_blends, rsp_info: latched pass-through.
- rsp_data  out  NUM_REQS×4×32  aligned texels.
- rsp_ready  in  1  sampler accepts output.

## Operation
- FSM states: IDLE, ISSUE, WAIT, OUTPUT. Reset → IDLE; all buffers and bookkeeping cleared.
- IDLE: req_ready=1. On req_valid: latch all request fields, issue index=0, issued/received masks=0 → ISSUE.
- ISSUE: mem_req_valid=1 with addresses for quad index q; on mem_req_ready set issued[q], advance q. After q=3 issued → WAIT (or OUTPUT if all 4 received).
- Responses are accepted in any state except IDLE: write mem_rsp_data into slot mem_rsp_tag, set received[tag]. Response with a tag already received, or arriving in IDLE, is a protocol error (assertion), data ignored.
- WAIT: when received==4'b1111 → OUTPUT.
- OUTPUT: rsp_valid=1; rsp_data[i][j] = slot[j][i] >> (8×addr[i][j][1:0]), zero-filled; lanes with tmask=0 output 0. On rsp_ready → IDLE.
- A response arriving in the same cycle as the issue of its own tag is legal and is recorded.
- tmask=0 request: still accepted; all four memory requests issued with mask 0; output all-zero data.

## Timing
- Reset outputs: req_ready=1 (IDLE), mem_req_valid=0, rsp_valid=0, mem_rsp_ready=1, all data outputs 0.
- Request accepted at cycle N → first mem_req_valid at N+1; with mem_req_ready held high, tags 0..3 issue at N+1..N+4.
- Received mask becomes complete at cycle M (last response edge) → rsp_valid at M+1 (registered).
- Minimum latency with zero-cycle memory: accept N → rsp_valid N+5. One request in flight; throughput ≥ 1 per 6 cycles.
- rsp_valid, rsp_data and the pass-through fields hold stable until rsp_ready.
- Reset asserted mid-operation: FSM → IDLE next cycle; outstanding responses are dropped, with no error reported until a new request is accepted.

## Configuration
- TEX_FETCH_DEDUP_EN defined: in ISSUE, quad index j>0 is skipped without a memory request when, for every active lane, addr[i][j][31:2] == addr[i][j-1][31:2]. Skipped index j is marked alias, counts as received once j-1 is received, and outputs word j-1 aligned with its own byte offset. Chains of aliases are allowed. The skip consumes one cycle with mem_req_valid=0.
- Undefined: every quad index is always issued; no alias logic is present.

## Test plan
- Lane0 addrs 0x100,0x104,0x108,0x10C; memory returns words 0xA..0xD in order, zero latency → rsp_data lane0 = {0xA,0xB,0xC,0xD} at accept+5; tags 0,1,2,3 issued on consecutive cycles.
- Responses returned in tag order 3,1,0,2 with 4-cycle gaps → rsp_valid exactly one cycle after tag 2 returns; slot placement correct.
- Byte offset: addr 0x102, word 0xAABBCCDD → texel 0x0000AABB.
- mem_req_ready low for 3 cycles on tag 1 → mem_req_addr/tag held stable; tag 2 not issued until tag 1 handshakes.
- rsp_ready low 5 cycles → outputs held stable, req_ready=0; reset pulse in WAIT → IDLE, rsp_valid=0, next request served correctly.
- With TEX_FETCH_DEDUP_EN: all four addrs = 0x200 → single mem request (tag 0), all texels equal returned word; without the macro → four requests.
